// File: rtl/axis_switch_nxm.sv
// axis_switch_nxm: N-input x M-output AXI-Stream crossbar with per-packet route locking.
//
// One input and one output are chosen per packet. The choice comes from in_sel/out_sel on
// the first beat and is held until the tlast beat is accepted. Beats pass through a
// main + skid register pair, so throughput is one beat per clock. Beats routed to an
// output index >= N_OUT are sunk and counted in drop_cnt, which saturates.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_sel        0 = idle, k = input channel k-1 (values > N_IN behave as 0)
//   out_sel       output channel; values >= N_OUT discard the packet
//   s_side        sideband sampled with each accepted beat
//   s_tdata/s_tlast/s_tvalid/s_tready   flattened input channels
//   m_tdata/m_tlast/m_side              shared output payload
//   m_tvalid/m_tready                   per-output handshake (m_tvalid one-hot or zero)
//   accept_pulse  one-cycle pulse per accepted input beat
//   busy          route lock held (packet in progress)
//   drop_cnt      saturating count of discarded beats
//
// Optional feature, macro AXIS_SWITCH_BEAT_CNT_EN: adds cnt_clr (synchronous clear of all
// counters, wins over increment) and beat_cnt (per-output wrapping delivered-beat counters).
module axis_switch_nxm #(
  parameter int unsigned DATA_W = 1536,
  parameter int unsigned LAST_W = 24,
  parameter int unsigned SIDE_W = 1,
  parameter int unsigned N_IN   = 6,
  parameter int unsigned N_OUT  = 9,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(N_IN+1)-1:0]   in_sel,
  input  logic [$clog2(N_OUT+1)-1:0]  out_sel,
  input  logic [SIDE_W-1:0]           s_side,
  input  logic [N_IN*DATA_W-1:0]      s_tdata,
  input  logic [N_IN*LAST_W-1:0]      s_tlast,
  input  logic [N_IN-1:0]             s_tvalid,
  output logic [N_IN-1:0]             s_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic [LAST_W-1:0]           m_tlast,
  output logic [SIDE_W-1:0]           m_side,
  output logic [N_OUT-1:0]            m_tvalid,
  input  logic [N_OUT-1:0]            m_tready,
  output logic                        accept_pulse,
  output logic                        busy,
  output logic [CNT_W-1:0]            drop_cnt
`ifdef AXIS_SWITCH_BEAT_CNT_EN
  ,
  input  logic                        cnt_clr,
  output logic [N_OUT*CNT_W-1:0]      beat_cnt
`endif
);

  localparam int unsigned IN_SEL_W  = $clog2(N_IN + 1);
  localparam int unsigned OUT_SEL_W = $clog2(N_OUT + 1);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic                 state_q;
  logic [IN_SEL_W-1:0]  held_in_q;
  logic [OUT_SEL_W-1:0] held_out_q;

  logic                 main_valid_q, skid_valid_q;
  logic [DATA_W-1:0]    main_data_q, skid_data_q;
  logic [LAST_W-1:0]    main_last_q, skid_last_q;
  logic [SIDE_W-1:0]    main_side_q, skid_side_q;
  logic [OUT_SEL_W-1:0] main_out_q, skid_out_q;
  logic [CNT_W-1:0]     drop_cnt_q;

  logic [IN_SEL_W-1:0]  eff_in;
  logic [OUT_SEL_W-1:0] eff_out;
  logic [DATA_W-1:0]    in_data;
  logic [LAST_W-1:0]    in_last;
  logic                 accept, in_last_any;
  logic                 out_ready, discard, drain, clr;

  // Input selection. Out-of-range selects match no channel, so nothing is ready.
  always_comb begin
    eff_in   = (state_q == ST_LOCKED) ? held_in_q  : in_sel;
    eff_out  = (state_q == ST_LOCKED) ? held_out_q : out_sel;
    in_data  = '0;
    in_last  = '0;
    s_tready = '0;
    for (int k = 0; k < int'(N_IN); k++) begin
      if (eff_in == IN_SEL_W'(k + 1)) begin
        in_data     = s_tdata[k*DATA_W +: DATA_W];
        in_last     = s_tlast[k*LAST_W +: LAST_W];
        // rst_n gating keeps every ready low while reset is held.
        s_tready[k] = ~skid_valid_q & rst_n;
      end
    end
    accept      = |(s_tvalid & s_tready);
    in_last_any = |in_last;
  end

  // Output decode from the index that travels with the beat in main.
  always_comb begin
    m_tvalid  = '0;
    out_ready = 1'b0;
    for (int j = 0; j < int'(N_OUT); j++) begin
      if (main_out_q == OUT_SEL_W'(j)) begin
        m_tvalid[j] = main_valid_q;
        out_ready   = m_tready[j];
      end
    end
    discard = main_valid_q & (main_out_q >= OUT_SEL_W'(N_OUT));
    drain   = main_valid_q & (discard | out_ready);
  end

`ifdef AXIS_SWITCH_BEAT_CNT_EN
  assign clr = cnt_clr;
`else
  assign clr = 1'b0;
`endif

  // Route lock: a multi-beat packet pins the selection until its tlast beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      held_in_q  <= '0;
      held_out_q <= '0;
    end else if (accept) begin
      if (state_q == ST_IDLE && !in_last_any) begin
        state_q    <= ST_LOCKED;
        held_in_q  <= in_sel;
        held_out_q <= out_sel;
      end else if (state_q == ST_LOCKED && in_last_any) begin
        state_q <= ST_IDLE;
      end
    end
  end

  // Main + skid slice. Skid only fills when main is held; ready depends on skid alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_last_q  <= '0;
      main_side_q  <= '0;
      main_out_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= '0;
      skid_side_q  <= '0;
      skid_out_q   <= '0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_valid_q <= 1'b1;
        main_data_q  <= skid_data_q;
        main_last_q  <= skid_last_q;
        main_side_q  <= skid_side_q;
        main_out_q   <= skid_out_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        main_valid_q <= 1'b1;
        main_data_q  <= in_data;
        main_last_q  <= in_last;
        main_side_q  <= s_side;
        main_out_q   <= eff_out;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data;
      skid_last_q  <= in_last;
      skid_side_q  <= s_side;
      skid_out_q   <= eff_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (clr) begin
      drop_cnt_q <= '0;
    end else if (discard && drop_cnt_q != {CNT_W{1'b1}}) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

`ifdef AXIS_SWITCH_BEAT_CNT_EN
  logic [N_OUT*CNT_W-1:0] beat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      for (int j = 0; j < int'(N_OUT); j++) begin
        if (clr) begin
          beat_cnt_q[j*CNT_W +: CNT_W] <= '0;
        end else if (m_tvalid[j] && m_tready[j]) begin
          beat_cnt_q[j*CNT_W +: CNT_W] <= beat_cnt_q[j*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

  assign m_tdata      = main_data_q;
  assign m_tlast      = main_last_q;
  assign m_side       = main_side_q;
  assign accept_pulse = accept;
  assign busy         = (state_q == ST_LOCKED);
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_axis_switch_nxm.sv
// Self-checking bench for axis_switch_nxm. The reference model treats the switch as a
// two-deep FIFO whose head is what the outputs show, plus a route lock that follows
// packet boundaries.
module tb_axis_switch_nxm;

  localparam int DW = 16;
  localparam int LW = 2;
  localparam int SW = 1;
  localparam int NI = 6;
  localparam int NO = 9;
  localparam int CW = 3;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0]           in_sel;
  logic [3:0]           out_sel;
  logic [SW-1:0]        s_side;
  logic [NI*DW-1:0]     s_tdata;
  logic [NI*LW-1:0]     s_tlast;
  logic [NI-1:0]        s_tvalid;
  logic [NI-1:0]        s_tready;
  logic [DW-1:0]        m_tdata;
  logic [LW-1:0]        m_tlast;
  logic [SW-1:0]        m_side;
  logic [NO-1:0]        m_tvalid;
  logic [NO-1:0]        m_tready;
  logic                 accept_pulse;
  logic                 busy;
  logic [CW-1:0]        drop_cnt;
`ifdef AXIS_SWITCH_BEAT_CNT_EN
  logic [NO*CW-1:0]     beat_cnt;
`endif

  axis_switch_nxm #(
    .DATA_W(DW), .LAST_W(LW), .SIDE_W(SW), .N_IN(NI), .N_OUT(NO), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_sel       (in_sel),
    .out_sel      (out_sel),
    .s_side       (s_side),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast),
    .m_side       (m_side),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .accept_pulse (accept_pulse),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
`ifdef AXIS_SWITCH_BEAT_CNT_EN
    ,
    .cnt_clr      (1'b0),
    .beat_cnt     (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [LW-1:0] l;
    logic [SW-1:0] s;
    int            dest;
  } beat_t;

  beat_t q[$];
  bit    m_locked;
  int    m_hin, m_hout, m_drop;
  int    n_cmp, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_locked = 1'b0;
    m_hin    = 0;
    m_hout   = 0;
    m_drop   = 0;
  endtask

  // Called just after a negedge with inputs set; compares, advances the model, and
  // returns at the next negedge. acc reports whether the model expects an accept.
  task automatic step(output bit acc);
    int            ein, eout;
    bit            rdy, drn;
    logic [NI-1:0] exp_rdy;
    logic [NO-1:0] exp_v;
    beat_t         b;
    #1;
    ein     = m_locked ? m_hin  : int'(in_sel);
    eout    = m_locked ? m_hout : int'(out_sel);
    rdy     = (ein >= 1) && (ein <= NI) && (q.size() < 2);
    exp_rdy = '0;
    acc     = 1'b0;
    if (rdy) begin
      exp_rdy[ein-1] = 1'b1;
      acc = s_tvalid[ein-1];
    end
    exp_v = '0;
    drn   = 1'b0;
    if (q.size() > 0) begin
      if (q[0].dest < NO) begin
        exp_v[q[0].dest] = 1'b1;
        drn = m_tready[q[0].dest];
        check("m_tdata", m_tdata, q[0].d);
        check("m_tlast", m_tlast, q[0].l);
        check("m_side", m_side, q[0].s);
      end else begin
        drn = 1'b1;
      end
    end
    check("s_tready", s_tready, exp_rdy);
    check("accept_pulse", accept_pulse, acc);
    check("busy", busy, m_locked);
    check("m_tvalid", m_tvalid, exp_v);
    check("drop_cnt", drop_cnt, m_drop);
    if (drn) begin
      if (q[0].dest >= NO && m_drop < DROP_MAX) m_drop++;
      void'(q.pop_front());
    end
    if (acc) begin
      b.d    = s_tdata[(ein-1)*DW +: DW];
      b.l    = s_tlast[(ein-1)*LW +: LW];
      b.s    = s_side;
      b.dest = eout;
      q.push_back(b);
      if (!m_locked && b.l == '0) begin
        m_locked = 1'b1;
        m_hin    = ein;
        m_hout   = eout;
      end else if (m_locked && b.l != '0) begin
        m_locked = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Drives an n-beat packet on channel ch (0-based). bp throttles m_tready with a
  // 1,0,0 pattern; chg_after > 0 moves the port selects after that many beats.
  task automatic send_pkt(input int ch, input int n, input bit bp, input int chg_after);
    int nb, cyc;
    bit acc;
    nb  = 0;
    cyc = 0;
    s_tvalid = '0;
    s_tvalid[ch] = 1'b1;
    while (nb < n && cyc < 40 * n) begin
      s_tdata[ch*DW +: DW] = DW'(16'hA000 + nb + 16 * ch);
      s_tlast[ch*LW +: LW] = (nb == n - 1) ? LW'(1) : '0;
      s_side = SW'(nb);
      m_tready = (!bp || (cyc % 3 == 0)) ? '1 : '0;
      step(acc);
      cyc++;
      if (acc) begin
        nb++;
        if (chg_after > 0 && nb == chg_after) begin
          in_sel  = 3'd3;
          out_sel = 4'd0;
        end
      end
    end
    check("pkt_beats_sent", nb, n);
    s_tvalid = '0;
  endtask

  task automatic drain(input int n);
    bit acc;
    s_tvalid = '0;
    m_tready = '1;
    repeat (n) step(acc);
  endtask

  initial begin
    bit acc;
    n_cmp    = 0;
    n_err    = 0;
    model_reset();
    rst_n    = 1'b0;
    in_sel   = 3'd3;
    out_sel  = 4'd4;
    s_side   = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    s_tvalid = '1;
    m_tready = '1;

    // Reset: nothing ready, nothing valid, even with a live select and valids.
    repeat (5) begin
      @(negedge clk);
      #1;
      check("rst_s_tready", s_tready, '0);
      check("rst_m_tvalid", m_tvalid, '0);
      check("rst_drop_cnt", drop_cnt, '0);
      check("rst_busy", busy, 1'b0);
    end
    rst_n    = 1'b1;
    in_sel   = 3'd0;
    repeat (3) step(acc);

    // Four-beat packet input 1 -> output 4, selects changed after beat 2.
    in_sel  = 3'd2;
    out_sel = 4'd4;
    send_pkt(1, 4, 1'b0, 2);
    // Next packet must follow the new selects: input 2 -> output 0.
    send_pkt(2, 3, 1'b0, 0);
    drain(3);

    // Backpressure on output 4, 20 beats.
    in_sel  = 3'd2;
    out_sel = 4'd4;
    send_pkt(1, 20, 1'b1, 0);
    drain(4);

    // Mid-packet reset with beats stuck in the slice.
    in_sel   = 3'd2;
    out_sel  = 4'd4;
    m_tready = '0;
    s_tvalid = 6'b000010;
    s_tlast  = '0;
    step(acc);
    step(acc);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_m_tvalid", m_tvalid, '0);
    check("midrst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_sel   = 3'd5;
    out_sel  = 4'd1;
    s_tvalid = 6'b010000;
    s_tlast[4*LW +: LW] = LW'(1);
    m_tready = '1;
    step(acc);
    drain(3);

    // Discard: 10 beats to an unmapped output, counter saturates.
    in_sel  = 3'd1;
    out_sel = 4'd9;
    send_pkt(0, 10, 1'b0, 0);
    drain(3);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) in_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)
        out_sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15))
                                              : 4'($urandom_range(0, 8));
      s_tvalid = NI'($urandom);
      for (int k = 0; k < NI; k++) begin
        s_tdata[k*DW +: DW] = DW'($urandom);
        s_tlast[k*LW +: LW] = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(1, 3)) : '0;
      end
      s_side   = SW'($urandom);
      m_tready = NO'($urandom | $urandom);
      step(acc);
    end
    drain(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
